ifft_frame_ctrl: RTL and testbench
==================================

IFFT_FRAME_CTRL -- requirements
Module: ifft_frame_ctrl

Interface
REQ-001 SHALL have parameter FRAME_LEN, default 64, samples per IFFT frame.
REQ-002 SHALL have parameter MAX_INFLIGHT, default 2, frames accepted by the FFT core but not yet output.
REQ-003 SHALL have parameter CFG_WORD, default 8'd1, FFT config word (inverse transform).
REQ-004 clk_80m  in  1  sole clock; all logic on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 fifo_rd_count  in  7  readable words in the input FIFO.
REQ-007 fifo_empty  in  1  input FIFO empty.
REQ-008 fifo_rd_en  out  1  input FIFO read strobe; data valid one cycle later.
REQ-009 fifo_dout  in  16  {im[7:0], re[7:0]}, signed.
REQ-010 cfg_tdata  out  8  FFT config data.
REQ-011 cfg_tvalid / cfg_tready  out / in  1 / 1  FFT config handshake.
REQ-012 s_tdata  out  32  FFT input, {im16, re16}.
REQ-013 s_tvalid / s_tready / s_tlast  out / in / out  1 each  FFT input stream.
REQ-014 m_tvalid, m_tlast  in  1 each  FFT output stream monitor (no backpressure driven).
REQ-015 ev_tlast_unexpected, ev_tlast_missing, ev_data_in_halt  in  1 each  FFT event pulses.
REQ-016 err_clr  in  1  clears err_flags.
REQ-017 err_flags  out  3  sticky {halt, missing, unexpected}.
REQ-018 busy  out  1  high in any state except STREAM_WAIT.
REQ-019 frames_done  out  16  completed output frames, wraps at 65535 -> 0.

Function
REQ-020 FSM states SHALL be IDLE, CFG, STREAM_WAIT, STREAM.
REQ-021 IDLE -> CFG one cycle after reset release.
REQ-022 CFG: cfg_tvalid=1, cfg_tdata=CFG_WORD; on cfg_tvalid&&cfg_tready, drop cfg_tvalid next cycle and go to STREAM_WAIT.
REQ-023 STREAM_WAIT -> STREAM when fifo_rd_count >= FRAME_LEN and inflight < MAX_INFLIGHT; inflight increments on that transition.
REQ-024 In STREAM, fifo_rd_en SHALL assert when reads_issued < FRAME_LEN, ~fifo_empty, and (buffered entries + outstanding read - pop this cycle) < 2.
REQ-025 Read data SHALL enter a 2-entry skid buffer; the head drives s_tdata with s_tvalid=1 when non-empty.
REQ-026 s_tdata SHALL be each 8-bit part sign-extended to 13 bits and left-shifted 3 ({5{b7}}, b, 3'b0), im upper 16, re lower 16.
REQ-027 s_tvalid SHALL NOT drop and s_tdata/s_tlast SHALL hold while s_tvalid && ~s_tready.
REQ-028 s_tlast SHALL be 1 only on the FRAME_LEN-th sample of the frame.
REQ-029 Handshake of the sample carrying s_tlast SHALL return FSM to STREAM_WAIT and zero reads_issued; no gap cycle required before next frame check.
REQ-030 inflight SHALL decrement on m_tvalid && m_tlast; simultaneous increment and decrement leave it unchanged; saturate at 0 and MAX_INFLIGHT.
REQ-031 frames_done SHALL increment on m_tvalid && m_tlast.
REQ-032 err_flags[0] sets on ev_tlast_unexpected, [1] on ev_tlast_missing, [2] on ev_data_in_halt only while in STREAM.
REQ-033 err_clr clears err_flags next cycle; a same-cycle event sets its bit (set wins).
REQ-034 fifo_empty during STREAM SHALL stall reads only; the frame completes when data resumes.

Reset
REQ-035 On rst: state IDLE, fifo_rd_en, cfg_tvalid, s_tvalid, s_tlast, s_tdata, err_flags, frames_done, inflight, buffer = 0; cfg_tdata = CFG_WORD.
REQ-036 Reset mid-frame SHALL discard buffered samples; config is reissued after release.

Configuration
REQ-037 With IFFT_CTRL_ERRCNT_EN defined: output err_count (8 bits), incremented on any REQ-032 bit-set event, saturating at 255, cleared by err_clr/rst; undefined: port and counter absent, err_flags unaffected.

Verification
REQ-038 Reset release, cfg_tready=1 on 3rd cycle -> one cfg handshake with tdata=0x01, FSM in STREAM_WAIT.
REQ-039 fifo_rd_count=64, s_tready=1, fifo_dout=0x80_7F -> 64 beats, re=0x03F8, im=0xFC00, s_tlast only on beat 64.
REQ-040 s_tready toggled 1/0 randomly -> 64 beats, data in order, no tdata change while stalled.
REQ-041 Two frames sent, no m_tlast -> third frame held in STREAM_WAIT; one m_tlast -> third starts, frames_done=1.
REQ-042 ev_tlast_missing and err_clr same cycle -> err_flags=3'b010; err_clr alone later -> 3'b000.
REQ-043 rst at beat 30 -> outputs zero immediately; after release, cfg reissued, next frame starts with beat 1.

Source files
------------

// File: rtl/ifft_frame_ctrl.sv
// Frame controller feeding an IFFT core: config handshake, FIFO-to-stream
// framing with a 2-entry skid buffer, in-flight frame limiting and event flags.
// Optional IFFT_CTRL_ERRCNT_EN adds a saturating err_count output.
module ifft_frame_ctrl #(
  parameter int         FRAME_LEN    = 64,
  parameter int         MAX_INFLIGHT = 2,
  parameter logic [7:0] CFG_WORD     = 8'd1
) (
  input  logic        clk_80m,
  input  logic        rst,
  input  logic [6:0]  fifo_rd_count,
  input  logic        fifo_empty,
  output logic        fifo_rd_en,
  input  logic [15:0] fifo_dout,
  output logic [7:0]  cfg_tdata,
  output logic        cfg_tvalid,
  input  logic        cfg_tready,
  output logic [31:0] s_tdata,
  output logic        s_tvalid,
  input  logic        s_tready,
  output logic        s_tlast,
  input  logic        m_tvalid,
  input  logic        m_tlast,
  input  logic        ev_tlast_unexpected,
  input  logic        ev_tlast_missing,
  input  logic        ev_data_in_halt,
  input  logic        err_clr,
  output logic [2:0]  err_flags,
  output logic        busy,
  output logic [15:0] frames_done
`ifdef IFFT_CTRL_ERRCNT_EN
  ,
  output logic [7:0]  err_count
`endif
);

  localparam int RW = $clog2(FRAME_LEN + 1);
  localparam int IW = $clog2(MAX_INFLIGHT + 1);
  localparam logic [RW-1:0] LEN_R  = RW'(FRAME_LEN);
  localparam logic [RW-1:0] LAST_R = RW'(FRAME_LEN - 1);
  localparam logic [IW-1:0] MAX_I  = IW'(MAX_INFLIGHT);
  localparam logic [7:0]    LEN_C  = 8'(FRAME_LEN);

  typedef enum logic [1:0] {
    IDLE,
    CFG,
    STREAM_WAIT,
    STREAM
  } state_t;

  state_t        state;
  logic [RW-1:0] reads_issued;
  logic [IW-1:0] inflight;
  logic          rd_pend;
  logic          rd_last;
  logic [1:0]    cnt;
  logic [31:0]   d0, d1;
  logic          l0, l1;

  logic        pop;
  logic        push;
  logic [2:0]  occ;
  logic        frame_ok;
  logic        start;
  logic        out_done;
  logic        last_hs;
  logic [2:0]  ev_set;
  logic [31:0] sample;

  // Sign-extend an 8-bit part and scale by 8 into a 16-bit lane.
  function automatic logic [15:0] widen(input logic [7:0] b);
    return {{5{b[7]}}, b, 3'b000};
  endfunction

  assign sample   = {widen(fifo_dout[15:8]), widen(fifo_dout[7:0])};
  assign s_tvalid = (cnt != 2'd0);
  assign s_tdata  = d0;
  assign s_tlast  = s_tvalid && l0;
  assign pop      = s_tvalid && s_tready;
  assign push     = rd_pend;
  assign occ      = {1'b0, cnt} + {2'b00, push} - {2'b00, pop};
  assign frame_ok = ({1'b0, fifo_rd_count} >= LEN_C) && (inflight < MAX_I);
  assign start    = (state == STREAM_WAIT) && frame_ok;
  assign out_done = m_tvalid && m_tlast;
  assign last_hs  = pop && s_tlast;
  assign busy     = (state != STREAM_WAIT);

  // Issue a read only when the buffer is guaranteed room on arrival.
  assign fifo_rd_en = (state == STREAM) && (reads_issued < LEN_R)
                   && !fifo_empty && (occ < 3'd2);

  assign ev_set = {ev_data_in_halt && (state == STREAM),
                   ev_tlast_missing, ev_tlast_unexpected};

  // Main control FSM: config, wait for a full frame, stream it.
  always_ff @(posedge clk_80m or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cfg_tvalid   <= 1'b0;
      cfg_tdata    <= CFG_WORD;
      reads_issued <= '0;
    end else begin
      cfg_tdata <= CFG_WORD;
      unique case (state)
        IDLE: begin
          state      <= CFG;
          cfg_tvalid <= 1'b1;
        end
        CFG: begin
          if (cfg_tvalid && cfg_tready) begin
            cfg_tvalid <= 1'b0;
            state      <= STREAM_WAIT;
          end
        end
        STREAM_WAIT: begin
          if (frame_ok) state <= STREAM;
        end
        STREAM: begin
          if (fifo_rd_en) reads_issued <= reads_issued + 1'b1;
          if (last_hs) begin
            state        <= STREAM_WAIT;
            reads_issued <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Track the read in flight and whether it carries the frame's last sample.
  always_ff @(posedge clk_80m or posedge rst) begin
    if (rst) begin
      rd_pend <= 1'b0;
      rd_last <= 1'b0;
    end else begin
      rd_pend <= fifo_rd_en;
      rd_last <= fifo_rd_en && (reads_issued == LAST_R);
    end
  end

  // Two-entry skid buffer; d0/l0 is the head presented on the stream.
  always_ff @(posedge clk_80m or posedge rst) begin
    if (rst) begin
      cnt <= 2'd0;
      d0  <= '0;
      d1  <= '0;
      l0  <= 1'b0;
      l1  <= 1'b0;
    end else begin
      cnt <= occ[1:0];
      unique case ({push, pop})
        2'b01: begin
          d0 <= d1;
          l0 <= l1;
        end
        2'b10: begin
          if (cnt == 2'd0) begin
            d0 <= sample;
            l0 <= rd_last;
          end else begin
            d1 <= sample;
            l1 <= rd_last;
          end
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            d0 <= sample;
            l0 <= rd_last;
          end else begin
            d0 <= d1;
            l0 <= l1;
            d1 <= sample;
            l1 <= rd_last;
          end
        end
        default: ;
      endcase
    end
  end

  // Frames held by the core and completed-frame counter.
  always_ff @(posedge clk_80m or posedge rst) begin
    if (rst) begin
      inflight    <= '0;
      frames_done <= '0;
    end else begin
      if (start && !out_done && inflight < MAX_I)
        inflight <= inflight + 1'b1;
      else if (out_done && !start && inflight != '0)
        inflight <= inflight - 1'b1;
      if (out_done) frames_done <= frames_done + 16'd1;
    end
  end

  // Sticky event flags; a same-cycle event beats the clear.
  always_ff @(posedge clk_80m or posedge rst) begin
    if (rst) err_flags <= '0;
    else     err_flags <= (err_clr ? 3'b000 : err_flags) | ev_set;
  end

`ifdef IFFT_CTRL_ERRCNT_EN
  // Saturating count of flag-setting events.
  always_ff @(posedge clk_80m or posedge rst) begin
    if (rst)
      err_count <= '0;
    else if (err_clr)
      err_count <= (|ev_set) ? 8'd1 : 8'd0;
    else if ((|ev_set) && err_count != 8'hFF)
      err_count <= err_count + 8'd1;
  end
`endif

endmodule

// File: tb/tb_ifft_frame_ctrl.sv
// Scoreboard bench for ifft_frame_ctrl: FIFO model feeds random samples,
// expected beats are queued on push and checked by a stream monitor.
module tb_ifft_frame_ctrl;

  localparam int FL = 64;

  logic        clk_80m = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  fifo_rd_count = '0;
  logic        fifo_empty = 1'b1;
  logic        fifo_rd_en;
  logic [15:0] fifo_dout = '0;
  logic [7:0]  cfg_tdata;
  logic        cfg_tvalid;
  logic        cfg_tready = 1'b0;
  logic [31:0] s_tdata;
  logic        s_tvalid;
  logic        s_tready = 1'b0;
  logic        s_tlast;
  logic        m_tvalid = 1'b0;
  logic        m_tlast = 1'b0;
  logic        ev_tlast_unexpected = 1'b0;
  logic        ev_tlast_missing = 1'b0;
  logic        ev_data_in_halt = 1'b0;
  logic        err_clr = 1'b0;
  logic [2:0]  err_flags;
  logic        busy;
  logic [15:0] frames_done;

  ifft_frame_ctrl dut (
    .clk_80m(clk_80m), .rst(rst),
    .fifo_rd_count(fifo_rd_count), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout),
    .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid),
    .cfg_tready(cfg_tready),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready), .s_tlast(s_tlast),
    .m_tvalid(m_tvalid), .m_tlast(m_tlast),
    .ev_tlast_unexpected(ev_tlast_unexpected),
    .ev_tlast_missing(ev_tlast_missing),
    .ev_data_in_halt(ev_data_in_halt),
    .err_clr(err_clr), .err_flags(err_flags),
    .busy(busy), .frames_done(frames_done)
  );

  always #6 clk_80m = ~clk_80m;

  int          checks = 0;
  int          fails = 0;
  logic [15:0] fq[$];
  logic [32:0] exp_q[$];
  int          push_cnt = 0;
  int          beats = 0;
  int          cfg_hs = 0;
  logic        rnd_ready = 1'b0;
  logic [31:0] last_data = '0;
  logic        last_tl = 1'b0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] scale(input logic [7:0] v);
    return 16'($signed(v) * 8);
  endfunction

  task automatic update_flags();
    fifo_empty    = (fq.size() == 0);
    fifo_rd_count = (fq.size() > 127) ? 7'd127 : 7'(fq.size());
  endtask

  task automatic push_word(input logic [15:0] w);
    fq.push_back(w);
    push_cnt++;
    exp_q.push_back({(push_cnt % FL) == 0, scale(w[15:8]), scale(w[7:0])});
    update_flags();
  endtask

  task automatic step();
    logic rd;
    @(negedge clk_80m);
    rd = fifo_rd_en;
    @(posedge clk_80m);
    #1;
    if (rd && fq.size() > 0) fifo_dout = fq.pop_front();
    update_flags();
    s_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic drain(input string name, input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      step();
      k++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k = 0;
    while (beats < n && k < budget) begin
      step();
      k++;
    end
    check("beat_wait", 32'(beats >= n), 32'd1);
  endtask

  task automatic pulse_m();
    m_tvalid = 1'b1;
    m_tlast  = 1'b1;
    step();
    m_tvalid = 1'b0;
    m_tlast  = 1'b0;
  endtask

  logic        pv = 1'b0;
  logic        pr = 1'b0;
  logic        pl = 1'b0;
  logic [31:0] pd = '0;
  logic [32:0] e;

  // Stream monitor: scoreboard pops, stall-hold and cfg handshake checks.
  always @(negedge clk_80m) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (pv && !pr) begin
        check("stall_valid", 32'(s_tvalid), 32'd1);
        check("stall_data", s_tdata, pd);
        check("stall_last", 32'(s_tlast), 32'(pl));
      end
      if (cfg_tvalid && cfg_tready) begin
        cfg_hs++;
        check("cfg_tdata", 32'(cfg_tdata), 32'h01);
      end
      if (s_tvalid && s_tready) begin
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_beat: got %0h expected none", s_tdata);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", s_tdata, e[31:0]);
          check("beat_tlast", 32'(s_tlast), 32'(e[32]));
        end
        beats++;
        last_data = s_tdata;
        last_tl   = s_tlast;
      end
      pv = s_tvalid;
      pr = s_tready;
      pd = s_tdata;
      pl = s_tlast;
    end
  end

  initial begin
    int b0;
    repeat (3) @(posedge clk_80m);
    #1;
    check("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("rst_cfg_valid", 32'(cfg_tvalid), 32'd0);
    check("rst_cfg_data", 32'(cfg_tdata), 32'h01);
    check("rst_s_valid", 32'(s_tvalid), 32'd0);
    check("rst_s_last", 32'(s_tlast), 32'd0);
    check("rst_s_data", s_tdata, 32'd0);
    check("rst_err", 32'(err_flags), 32'd0);
    check("rst_frames", 32'(frames_done), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);

    rst = 1'b0;
    step();
    step();
    cfg_tready = 1'b1;
    run(3);
    check("cfg_hs_count", 32'(cfg_hs), 32'd1);
    check("cfg_valid_drop", 32'(cfg_tvalid), 32'd0);
    check("cfg_to_wait", 32'(busy), 32'd0);

    for (int i = 0; i < FL; i++) push_word(16'h807F);
    drain("frame1_drain", 400);
    check("frame1_beats", 32'(beats), 32'd64);
    check("frame1_data", last_data, 32'hFC00_03F8);
    check("frame1_last", 32'(last_tl), 32'd1);
    check("frame1_idle", 32'(busy), 32'd0);
    pulse_m();
    check("frames_done_1", 32'(frames_done), 32'd1);

    rnd_ready = 1'b1;
    for (int i = 0; i < FL; i++) push_word(16'($urandom));
    drain("frame2_drain", 1500);
    rnd_ready = 1'b0;
    for (int i = 0; i < FL; i++) push_word(16'($urandom));
    drain("frame3_drain", 400);

    for (int i = 0; i < FL; i++) push_word(16'($urandom));
    run(20);
    check("hold_valid", 32'(s_tvalid), 32'd0);
    check("hold_wait", 32'(busy), 32'd0);
    check("hold_fifo", 32'(fq.size()), 32'd64);
    m_tvalid = 1'b1;
    step();
    m_tvalid = 1'b0;
    check("m_no_last", 32'(frames_done), 32'd1);
    pulse_m();
    drain("frame4_drain", 400);
    check("frames_done_2", 32'(frames_done), 32'd2);

    ev_tlast_missing = 1'b1;
    err_clr = 1'b1;
    step();
    ev_tlast_missing = 1'b0;
    err_clr = 1'b0;
    check("err_set_wins", 32'(err_flags), 32'b010);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("err_clear", 32'(err_flags), 32'b000);
    ev_data_in_halt = 1'b1;
    step();
    ev_data_in_halt = 1'b0;
    check("halt_outside", 32'(err_flags), 32'b000);
    ev_tlast_unexpected = 1'b1;
    step();
    ev_tlast_unexpected = 1'b0;
    check("err_unexp", 32'(err_flags), 32'b001);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;

    pulse_m();
    pulse_m();
    check("frames_done_4", 32'(frames_done), 32'd4);
    b0 = beats;
    for (int i = 0; i < FL; i++) push_word(16'($urandom));
    wait_beats(b0 + 10, 200);
    ev_data_in_halt = 1'b1;
    step();
    ev_data_in_halt = 1'b0;
    check("halt_in_stream", 32'(err_flags), 32'b100);
    wait_beats(b0 + 30, 200);

    rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(s_tvalid), 32'd0);
    check("mid_rst_data", s_tdata, 32'd0);
    check("mid_rst_last", 32'(s_tlast), 32'd0);
    check("mid_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check("mid_rst_err", 32'(err_flags), 32'd0);
    check("mid_rst_frames", 32'(frames_done), 32'd0);
    fq.delete();
    exp_q.delete();
    push_cnt = 0;
    update_flags();
    cfg_hs = 0;
    run(2);
    rst = 1'b0;
    run(5);
    check("recfg_hs", 32'(cfg_hs), 32'd1);
    check("recfg_wait", 32'(busy), 32'd0);

    b0 = beats;
    rnd_ready = 1'b1;
    for (int i = 0; i < FL; i++) push_word(16'($urandom));
    drain("post_rst_drain", 1500);
    rnd_ready = 1'b0;
    check("post_rst_beats", 32'(beats - b0), 32'd64);
    check("post_rst_last", 32'(last_tl), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
